// File: rtl/fs_accel_pkg.sv
// Shared definitions for the fs_accel weight-buffer sequencer: FSM encoding,
// buffer bank-select codes and kernel geometry.
package fs_accel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        READY = 2'd3
    } wbuf_state_e;

    localparam logic [1:0] BANK_NONE = 2'd0;
    localparam logic [1:0] BANK_W0   = 2'd1;
    localparam logic [1:0] BANK_W1   = 2'd2;
    localparam logic [1:0] BANK_W2   = 2'd3;

    localparam int KERN_WORDS = 3;
    localparam int KERN_COLS  = 3;

    function automatic logic [1:0] bank_of(input logic [1:0] word_idx);
        case (word_idx)
            2'd0:    bank_of = BANK_W0;
            2'd1:    bank_of = BANK_W1;
            default: bank_of = BANK_W2;
        endcase
    endfunction

endpackage

// File: rtl/fs_accel_wbuf_ctrl.sv
// 3x3 kernel weight-buffer sequencer: three word fetches at any byte alignment,
// then one buffer shift per consumed column. Optional stall counter: FS_WBUF_CTRL_PERF_EN.
module fs_accel_wbuf_ctrl
    import fs_accel_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [7:0]  INIT_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] kern_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              col_valid,
    output logic [1:0]        col_idx,
    input  logic              step,
    output logic [31:0]       wbuf_di,
    output logic [7:0]        wbuf_init,
    output logic [1:0]        wbuf_wstrb,
    output logic              wbuf_ld_wrn,
    output logic [1:0]        wbuf_bank_sel,
`ifdef FS_WBUF_CTRL_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              wbuf_enb
);

    localparam logic [1:0] LAST_WORD = 2'(KERN_WORDS - 1);
    localparam logic [1:0] LAST_COL  = 2'(KERN_COLS - 1);

    wbuf_state_e       state, state_nxt;
    logic [1:0]        k, k_nxt;
    logic [1:0]        c, c_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [1:0]        off, off_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            k     <= 2'd0;
            c     <= 2'd0;
            base  <= '0;
            off   <= 2'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            c     <= c_nxt;
            base  <= base_nxt;
            off   <= off_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        c_nxt     = c;
        base_nxt  = base;
        off_nxt   = off;
        case (state)
            IDLE: begin
                if (start) begin
                    base_nxt  = {kern_addr[ADDR_W-1:2], 2'b00};
                    off_nxt   = kern_addr[1:0];
                    k_nxt     = 2'd0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    if (k != LAST_WORD) begin
                        k_nxt     = k + 2'd1;
                        state_nxt = REQ;
                    end else begin
                        c_nxt     = 2'd0;
                        state_nxt = READY;
                    end
                end
            end
            READY: begin
                if (step) begin
                    if (c != LAST_COL) begin
                        c_nxt = c + 2'd1;
                    end else begin
                        c_nxt     = 2'd0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        mem_req_valid = (state == REQ);
        mem_req_addr  = base + ADDR_W'({k, 2'b00});
        col_valid     = (state == READY);
        col_idx       = c;
        done          = 1'b0;
        wbuf_di       = mem_rsp_data;
        wbuf_init     = INIT_BYTE;
        wbuf_wstrb    = off;
        wbuf_enb      = 1'b0;
        wbuf_ld_wrn   = 1'b0;
        wbuf_bank_sel = BANK_NONE;
        if (state == WAIT && mem_rsp_valid) begin
            wbuf_enb      = 1'b1;
            wbuf_ld_wrn   = 1'b1;
            wbuf_bank_sel = bank_of(k);
        end else if (state == READY && step) begin
            wbuf_enb = 1'b1;
            done     = (c == LAST_COL);
        end
    end

`ifdef FS_WBUF_CTRL_PERF_EN
    // Counts memory-side stall cycles of the current load; saturates.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cnt <= 16'd0;
        end else if (((state == REQ && !mem_req_ready) || (state == WAIT && !mem_rsp_valid))
                     && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fs_accel_wbuf_ctrl.sv
// Directed self-checking bench for fs_accel_wbuf_ctrl; memory and consumer are
// driven inline, expected values are hand-computed constants.
module tb_fs_accel_wbuf_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] kern_addr;
    logic        busy;
    logic        done;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        col_valid;
    logic [1:0]  col_idx;
    logic        step;
    logic [31:0] wbuf_di;
    logic [7:0]  wbuf_init;
    logic [1:0]  wbuf_wstrb;
    logic        wbuf_ld_wrn;
    logic [1:0]  wbuf_bank_sel;
    logic        wbuf_enb;
`ifdef FS_WBUF_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int tests  = 0;
    int fails  = 0;
    int cycles = 0;
    int t0;

    fs_accel_wbuf_ctrl #(.ADDR_W(32), .INIT_BYTE(8'hA5)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .kern_addr     (kern_addr),
        .busy          (busy),
        .done          (done),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .col_valid     (col_valid),
        .col_idx       (col_idx),
        .step          (step),
        .wbuf_di       (wbuf_di),
        .wbuf_init     (wbuf_init),
        .wbuf_wstrb    (wbuf_wstrb),
        .wbuf_ld_wrn   (wbuf_ld_wrn),
        .wbuf_bank_sel (wbuf_bank_sel),
`ifdef FS_WBUF_CTRL_PERF_EN
        .stall_cnt     (stall_cnt),
`endif
        .wbuf_enb      (wbuf_enb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // Serves one word: optional ready stall, accept, optional response delay, response.
    task automatic serve_word(input logic [1:0] k, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] off, input int req_stall, input int rsp_delay);
        mem_req_ready = 1'b0;
        for (int i = 0; i < req_stall; i++) begin
            #1;
            check("req_hold_valid", 32'(mem_req_valid), 32'd1);
            check("req_hold_addr", mem_req_addr, addr);
            cyc();
        end
        mem_req_ready = 1'b1;
        #1;
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_req_addr, addr);
        check("req_no_enb", 32'(wbuf_enb), 32'd0);
        cyc();
        mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            #1;
            check("wait_no_enb", 32'(wbuf_enb), 32'd0);
            check("wait_bank_none", 32'(wbuf_bank_sel), 32'd0);
            check("wait_no_colv", 32'(col_valid), 32'd0);
            cyc();
            check("wait_stays_wait", {30'd0, busy, mem_req_valid}, 32'd2);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        #1;
        check("ld_enb", 32'(wbuf_enb), 32'd1);
        check("ld_ld_wrn", 32'(wbuf_ld_wrn), 32'd1);
        check("ld_bank", 32'(wbuf_bank_sel), 32'(k) + 32'd1);
        check("ld_di", wbuf_di, data);
        check("ld_wstrb", 32'(wbuf_wstrb), 32'(off));
        check("ld_colv_low", 32'(col_valid), 32'd0);
        cyc();
        mem_rsp_valid = 1'b0;
    endtask

    // Three step pulses from READY; a start raised with the done pulse must be ignored.
    task automatic consume();
        for (int col = 0; col < 3; col++) begin
            step  = 1'b1;
            start = (col == 2);
            #1;
            check("col_valid", 32'(col_valid), 32'd1);
            check("col_idx", 32'(col_idx), 32'(col));
            check("shift_enb", 32'(wbuf_enb), 32'd1);
            check("shift_ld_wrn", 32'(wbuf_ld_wrn), 32'd0);
            check("shift_bank", 32'(wbuf_bank_sel), 32'd0);
            check("done", 32'(done), (col == 2) ? 32'd1 : 32'd0);
            check("busy_ready", 32'(busy), 32'd1);
            cyc();
        end
        step  = 1'b0;
        start = 1'b0;
        #1;
        check("post_done_busy", 32'(busy), 32'd0);
        check("post_done_colv", 32'(col_valid), 32'd0);
        check("post_done_pulse", 32'(done), 32'd0);
        check("post_done_idx", 32'(col_idx), 32'd0);
        cyc();
        check("start_at_done_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        start         = 1'b0;
        kern_addr     = 32'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        step          = 1'b0;
        cyc();
        cyc();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_col_valid", 32'(col_valid), 32'd0);
        check("rst_col_idx", 32'(col_idx), 32'd0);
        check("rst_enb", 32'(wbuf_enb), 32'd0);
        check("rst_ld_wrn", 32'(wbuf_ld_wrn), 32'd0);
        check("rst_bank", 32'(wbuf_bank_sel), 32'd0);
        check("init_byte", 32'(wbuf_init), 32'h0000_00A5);
        resetn = 1'b1;
        cyc();

        // 1. Aligned load with minimum latency.
        start     = 1'b1;
        kern_addr = 32'h0000_0100;
        t0        = cycles;
        cyc();
        start = 1'b0;
        serve_word(2'd0, 32'h0000_0100, 32'h0302_0100, 2'd0, 0, 0);
        serve_word(2'd1, 32'h0000_0104, 32'h0706_0504, 2'd0, 0, 0);
        serve_word(2'd2, 32'h0000_0108, 32'h0B0A_0908, 2'd0, 0, 0);
        check("latency", 32'(cycles - t0), 32'd7);
        check("t1_col_valid", 32'(col_valid), 32'd1);
        // 4. Column stepping.
        consume();

        // 2. Unaligned load.
        start     = 1'b1;
        kern_addr = 32'h0000_0203;
        cyc();
        start = 1'b0;
        serve_word(2'd0, 32'h0000_0200, 32'h1312_1110, 2'd3, 0, 0);
        serve_word(2'd1, 32'h0000_0204, 32'h1716_1514, 2'd3, 0, 0);
        serve_word(2'd2, 32'h0000_0208, 32'h1B1A_1918, 2'd3, 0, 0);
        consume();

        // 3. Back-pressure on the second request.
        start     = 1'b1;
        kern_addr = 32'h0000_0300;
        cyc();
        start = 1'b0;
        serve_word(2'd0, 32'h0000_0300, 32'h2322_2120, 2'd0, 0, 0);
        serve_word(2'd1, 32'h0000_0304, 32'h2726_2524, 2'd0, 4, 0);
        serve_word(2'd2, 32'h0000_0308, 32'h2B2A_2928, 2'd0, 0, 0);
`ifdef FS_WBUF_CTRL_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'd4);
`endif
        consume();

        // 5. Ignored inputs, on a load that wraps the top of memory.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        check("idle_rsp_no_enb", 32'(wbuf_enb), 32'd0);
        check("idle_rsp_bank", 32'(wbuf_bank_sel), 32'd0);
        cyc();
        check("idle_rsp_no_busy", 32'(busy), 32'd0);
        mem_rsp_valid = 1'b0;
        start         = 1'b1;
        kern_addr     = 32'hFFFF_FFF9;
        cyc();
        kern_addr = 32'h0000_0500;
        step      = 1'b1;
        serve_word(2'd0, 32'hFFFF_FFF8, 32'h3332_3130, 2'd1, 1, 2);
        serve_word(2'd1, 32'hFFFF_FFFC, 32'h3736_3534, 2'd1, 0, 0);
        start = 1'b0;
        step  = 1'b0;
        serve_word(2'd2, 32'h0000_0000, 32'h3B3A_3938, 2'd1, 0, 0);
        consume();

        // 6. Reset while waiting on the second word.
        start     = 1'b1;
        kern_addr = 32'h0000_0600;
        cyc();
        start = 1'b0;
        serve_word(2'd0, 32'h0000_0600, 32'h4342_4140, 2'd0, 0, 0);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        check("pre_rst_in_wait", {30'd0, busy, mem_req_valid}, 32'd2);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_col_valid", 32'(col_valid), 32'd0);
        check("midrst_col_idx", 32'(col_idx), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h4746_4544;
        #1;
        check("stale_rsp_enb", 32'(wbuf_enb), 32'd0);
        check("stale_rsp_bank", 32'(wbuf_bank_sel), 32'd0);
        check("stale_rsp_ld", 32'(wbuf_ld_wrn), 32'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        check("stale_rsp_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
